// File: rtl/logic_func_identifier_if.sv
// Operand-side bus between the logic-function identifier and the logic unit under test.
// master: identifier side; slave: logic unit / requester side.
interface logic_func_identifier_if;
   logic       start;
   logic       e_in;
   logic       a_out;
   logic       b_out;
   logic       busy;
   logic       done;
   logic [2:0] op_code;
   logic       error;

   modport master (
      input  start,
      input  e_in,
      output a_out,
      output b_out,
      output busy,
      output done,
      output op_code,
      output error
   );

   modport slave (
      output start,
      output e_in,
      input  a_out,
      input  b_out,
      input  busy,
      input  done,
      input  op_code,
      input  error
   );
endinterface

// File: rtl/logic_func_identifier.sv
// Sweeps all A/B vectors into a 3-bit-selected logic unit and decodes its select code.
// Optional LOGIC_FUNC_ID_RECHECK_EN runs a second sweep and flags a select change mid-run.
module logic_func_identifier #(
   parameter int unsigned SETTLE = 1
) (
   input logic                   clk,
   input logic                   rst,
   logic_func_identifier_if.master bus
);

   typedef enum logic [1:0] {StIdle, StApply, StDecode, StDone} state_e;

   state_e     state_q;
   logic [1:0] i_q;
   logic [3:0] cnt_q;
   logic [3:0] tt_q;
   logic       a_q;
   logic       b_q;
   logic       busy_q;
   logic       done_q;
   logic [2:0] op_q;
   logic       err_q;
   logic [2:0] dec_op;
   logic       dec_err;

`ifdef LOGIC_FUNC_ID_RECHECK_EN
   logic       pass_q;
   logic [3:0] tt2_q;
`endif

   always_comb begin
      dec_op  = 3'd0;
      dec_err = 1'b0;
      case (tt_q)
         4'b1000: dec_op = 3'd0;
         4'b1110: dec_op = 3'd1;
         4'b0110: dec_op = 3'd2;
         4'b1001: dec_op = 3'd3;
         4'b0111: dec_op = 3'd4;
         4'b0001: dec_op = 3'd5;
         4'b0011: dec_op = 3'd6;
         4'b1100: dec_op = 3'd7;
         default: dec_err = 1'b1;
      endcase
`ifdef LOGIC_FUNC_ID_RECHECK_EN
      if (tt2_q != tt_q) begin
         dec_op  = 3'd0;
         dec_err = 1'b1;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         i_q     <= 2'd0;
         cnt_q   <= 4'd0;
         tt_q    <= 4'd0;
         a_q     <= 1'b0;
         b_q     <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         op_q    <= 3'd0;
         err_q   <= 1'b0;
`ifdef LOGIC_FUNC_ID_RECHECK_EN
         pass_q  <= 1'b0;
         tt2_q   <= 4'd0;
`endif
      end else begin
         done_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               a_q <= 1'b0;
               b_q <= 1'b0;
               if (bus.start) begin
                  i_q     <= 2'd0;
                  cnt_q   <= 4'(SETTLE);
                  busy_q  <= 1'b1;
                  state_q <= StApply;
`ifdef LOGIC_FUNC_ID_RECHECK_EN
                  pass_q  <= 1'b0;
`endif
               end
            end
            StApply: begin
               if (cnt_q == 4'd1) begin
`ifdef LOGIC_FUNC_ID_RECHECK_EN
                  if (pass_q) tt2_q[i_q] <= bus.e_in;
                  else        tt_q[i_q]  <= bus.e_in;
`else
                  tt_q[i_q] <= bus.e_in;
`endif
                  cnt_q <= 4'(SETTLE);
                  if (i_q == 2'd3) begin
                     i_q        <= 2'd0;
                     {a_q, b_q} <= 2'b00;
`ifdef LOGIC_FUNC_ID_RECHECK_EN
                     if (pass_q) state_q <= StDecode;
                     else        pass_q  <= 1'b1;
`else
                     state_q <= StDecode;
`endif
                  end else begin
                     // Operands follow the index so vector i is held for SETTLE cycles.
                     i_q        <= i_q + 2'd1;
                     {a_q, b_q} <= i_q + 2'd1;
                  end
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            StDecode: begin
               op_q    <= dec_op;
               err_q   <= dec_err;
               done_q  <= 1'b1;
               state_q <= StDone;
            end
            StDone: begin
               busy_q  <= 1'b0;
               state_q <= StIdle;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.a_out   = a_q;
   assign bus.b_out   = b_q;
   assign bus.busy    = busy_q;
   assign bus.done    = done_q;
   assign bus.op_code = op_q;
   assign bus.error   = err_q;

endmodule
